// File: rtl/icache_axi_refill_unit_pkg.sv
// Shared types and sizing helpers for the icache AXI refill unit.
package icache_axi_refill_unit_pkg;

  localparam int unsigned ICACHE_LINE_WIDTH = 128;
  localparam int unsigned PaddrWidth        = 64;
  localparam int unsigned IcacheTidWidth    = 2;
  localparam logic [1:0]  AxiBurstIncr      = 2'b01;

  // IFILL_ACK encodes as zero so an all-zero return word is a legal idle value.
  typedef enum logic [1:0] {
    ICACHE_IFILL_ACK = 2'd0,
    ICACHE_INV_REQ   = 2'd1
  } icache_rtype_e;

  typedef struct packed {
    logic       vld;
    logic       all;
    logic [7:0] idx;
    logic [1:0] way;
  } icache_inv_t;

  typedef struct packed {
    logic [PaddrWidth-1:0]     paddr;
    logic                      nc;
    logic [IcacheTidWidth-1:0] tid;
  } icache_req_t;

  typedef struct packed {
    icache_rtype_e                rtype;
    logic [ICACHE_LINE_WIDTH-1:0] data;
    icache_inv_t                  inv;
    logic [IcacheTidWidth-1:0]    tid;
  } icache_rtrn_t;

  typedef struct packed {
    logic                      valid;
    logic                      nc;
    logic [IcacheTidWidth-1:0] tid;
  } icache_refill_slot_t;

  function automatic int unsigned ICACHE_REFILL_BEATS(input int unsigned line_w,
                                                      input int unsigned data_w);
    return line_w / data_w;
  endfunction

  // Bits needed to pick a 64-bit lane out of one data beat (at least one).
  function automatic int unsigned icache_refill_lane_width(input int unsigned data_w);
    return (data_w > 64) ? $clog2(data_w / 64) : 1;
  endfunction

endpackage

// File: rtl/icache_axi_refill_unit_if.sv
// AXI4 read-channel bundle (plus write-side tie-offs) for the icache refill unit.
interface icache_axi_refill_unit_if #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4
);
  logic                    ar_valid;
  logic                    ar_ready;
  logic [AxiAddrWidth-1:0] ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [AxiIdWidth-1:0]   ar_id;

  logic                    r_valid;
  logic                    r_ready;
  logic [AxiDataWidth-1:0] r_data;
  logic [AxiIdWidth-1:0]   r_id;
  logic [1:0]              r_resp;
  logic                    r_last;

  logic                    aw_valid;
  logic                    w_valid;
  logic                    b_ready;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, r_ready,
    output aw_valid, w_valid, b_ready,
    input  ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, r_ready,
    input  aw_valid, w_valid, b_ready,
    output ar_ready, r_valid, r_data, r_id, r_resp, r_last
  );
endinterface

// File: rtl/icache_axi_refill_unit_slot.sv
// One refill slot: holds tid/nc, beat counter, line buffer and sticky error bit.
module icache_refill_slot
  import icache_axi_refill_unit_pkg::*;
#(
  parameter int unsigned LineWidth    = ICACHE_LINE_WIDTH,
  parameter int unsigned AxiDataWidth = 64
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic                                                clr_i,
  input  logic                                                alloc_i,
  input  logic                                                alloc_nc_i,
  input  logic [IcacheTidWidth-1:0]                           alloc_tid_i,
  input  logic [icache_refill_lane_width(AxiDataWidth)-1:0]   alloc_lane_i,
  input  logic                                                beat_i,
  input  logic [AxiDataWidth-1:0]                             beat_data_i,
  input  logic                                                beat_err_i,
  input  logic                                                beat_last_i,
  output logic                                                valid_o,
  output logic [IcacheTidWidth-1:0]                           tid_o,
  output logic [LineWidth-1:0]                                line_o,
  output logic                                                err_o,
  output logic                                                last_beat_o
);
  localparam int unsigned Beats = ICACHE_REFILL_BEATS(LineWidth, AxiDataWidth);
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned LaneW = icache_refill_lane_width(AxiDataWidth);
  localparam int unsigned Lanes = AxiDataWidth / 64;

  icache_refill_slot_t meta_q, meta_d;
  logic [LaneW-1:0]     lane_q, lane_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [LineWidth-1:0] line_q, line_d;
  logic                 err_q, err_d;

  always_comb begin
    meta_d = meta_q;
    lane_d = lane_q;
    cnt_d  = cnt_q;
    line_d = line_q;
    err_d  = err_q;
    if (alloc_i) begin
      meta_d = '{valid: 1'b1, nc: alloc_nc_i, tid: alloc_tid_i};
      lane_d = alloc_lane_i;
      cnt_d  = '0;
      line_d = '0;
      err_d  = 1'b0;
    end else if (beat_i && meta_q.valid) begin
      if (meta_q.nc) begin
        // Bypass: only the addressed 64-bit word survives, placed at word 0.
        line_d = '0;
        for (int unsigned l = 0; l < Lanes; l++) begin
          if (lane_q == LaneW'(l)) line_d[63:0] = beat_data_i[l*64 +: 64];
        end
      end else begin
        for (int unsigned b = 0; b < Beats; b++) begin
          if (cnt_q == CntW'(b)) line_d[b*AxiDataWidth +: AxiDataWidth] = beat_data_i;
        end
      end
      err_d = err_q | beat_err_i;
      if (beat_last_i) begin
        cnt_d        = '0;
        meta_d.valid = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      lane_q <= '0;
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (clr_i) begin
      meta_q <= '0;
      lane_q <= '0;
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
      err_q  <= err_d;
    end
  end

  // Line and error include the beat arriving this cycle so RLAST can capture them directly.
  assign line_o      = line_d;
  assign err_o       = err_d;
  assign valid_o     = meta_q.valid;
  assign tid_o       = meta_q.tid;
  assign last_beat_o = meta_q.nc | (cnt_q == CntW'(Beats - 1));

endmodule

// File: rtl/icache_axi_refill_unit.sv
// Multi-outstanding icache refill engine over an AXI4 read channel.
// Optional CVA6_ICACHE_REFILL_ERR_EN adds err_o and zeroes data of refills that saw RRESP[1].
module icache_axi_refill_unit
  import icache_axi_refill_unit_pkg::*;
#(
  parameter int unsigned LineWidth      = ICACHE_LINE_WIDTH,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned NumOutstanding = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         mem_data_req_i,
  output logic         mem_data_ack_o,
  input  icache_req_t  mem_data_i,
  output logic         mem_rtrn_vld_o,
  output icache_rtrn_t mem_rtrn_o,
  output logic         busy_o,
`ifdef CVA6_ICACHE_REFILL_ERR_EN
  output logic         err_o,
`endif
  icache_axi_refill_unit_if.master axi
);
  localparam int unsigned Beats = ICACHE_REFILL_BEATS(LineWidth, AxiDataWidth);
  localparam int unsigned SlotW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned LaneW = icache_refill_lane_width(AxiDataWidth);
  localparam logic [PaddrWidth-1:0] LineMask = ~PaddrWidth'(LineWidth / 8 - 1);
  localparam logic [PaddrWidth-1:0] WordMask = ~PaddrWidth'(7);
  localparam logic [7:0] ArLenLine  = 8'(Beats - 1);
  localparam logic [2:0] ArSizeLine = 3'($clog2(AxiDataWidth / 8));

  logic [NumOutstanding-1:0] slot_valid, slot_last, slot_err, slot_alloc, slot_hit;
  logic [IcacheTidWidth-1:0] slot_tid  [NumOutstanding];
  logic [LineWidth-1:0]      slot_line [NumOutstanding];

  logic [SlotW-1:0] alloc_idx;
  logic [LaneW-1:0] alloc_lane;
  logic             accept, beat_err, rid_alloc;

  logic                      ar_valid_q, ar_valid_d;
  logic [AxiAddrWidth-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [AxiIdWidth-1:0]     ar_id_q, ar_id_d;
  logic                      rtrn_vld_q, rtrn_vld_d;
  logic [LineWidth-1:0]      rtrn_data_q, rtrn_data_d;
  logic [IcacheTidWidth-1:0] rtrn_tid_q, rtrn_tid_d;
  logic                      rtrn_err_q, rtrn_err_d;

  always_comb begin
    alloc_idx = '0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (!slot_valid[i]) alloc_idx = SlotW'(i);
    end
    accept = mem_data_req_i & ~(&slot_valid) & ~ar_valid_q;
    for (int i = 0; i < NumOutstanding; i++) begin
      slot_alloc[i] = accept && (alloc_idx == SlotW'(i));
      slot_hit[i]   = axi.r_valid && (axi.r_id == AxiIdWidth'(i));
    end
    alloc_lane = (AxiDataWidth > 64) ? mem_data_i.paddr[3 +: LaneW] : '0;
  end

`ifdef CVA6_ICACHE_REFILL_ERR_EN
  assign beat_err = axi.r_resp[1];
  assign err_o    = rtrn_err_q;
`else
  logic unused_err;
  assign beat_err   = 1'b0;
  assign unused_err = ^{axi.r_resp, rtrn_err_q};
`endif

  for (genvar i = 0; i < NumOutstanding; i++) begin : g_slot
    icache_refill_slot #(
      .LineWidth    (LineWidth),
      .AxiDataWidth (AxiDataWidth)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (clr_i),
      .alloc_i      (slot_alloc[i]),
      .alloc_nc_i   (mem_data_i.nc),
      .alloc_tid_i  (mem_data_i.tid),
      .alloc_lane_i (alloc_lane),
      .beat_i       (slot_hit[i]),
      .beat_data_i  (axi.r_data),
      .beat_err_i   (beat_err),
      .beat_last_i  (axi.r_last),
      .valid_o      (slot_valid[i]),
      .tid_o        (slot_tid[i]),
      .line_o       (slot_line[i]),
      .err_o        (slot_err[i]),
      .last_beat_o  (slot_last[i])
    );
  end

  // AR register: fields frozen while ARVALID waits for ARREADY.
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_id_d    = ar_id_q;
    if (ar_valid_q && axi.ar_ready) ar_valid_d = 1'b0;
    if (accept) begin
      ar_valid_d = 1'b1;
      ar_id_d    = AxiIdWidth'(alloc_idx);
      if (mem_data_i.nc) begin
        ar_addr_d = AxiAddrWidth'(mem_data_i.paddr & WordMask);
        ar_len_d  = 8'd0;
        ar_size_d = 3'd3;
      end else begin
        ar_addr_d = AxiAddrWidth'(mem_data_i.paddr & LineMask);
        ar_len_d  = ArLenLine;
        ar_size_d = ArSizeLine;
      end
    end
  end

  always_comb begin
    rtrn_vld_d  = 1'b0;
    rtrn_data_d = rtrn_data_q;
    rtrn_tid_d  = rtrn_tid_q;
    rtrn_err_d  = rtrn_err_q;
    for (int i = 0; i < NumOutstanding; i++) begin
      if (slot_hit[i] && axi.r_last) begin
        rtrn_vld_d  = 1'b1;
        rtrn_data_d = slot_err[i] ? '0 : slot_line[i];
        rtrn_tid_d  = slot_tid[i];
        rtrn_err_d  = slot_err[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_id_q     <= '0;
      rtrn_vld_q  <= 1'b0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
      rtrn_err_q  <= 1'b0;
    end else if (clr_i) begin
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_id_q     <= '0;
      rtrn_vld_q  <= 1'b0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
      rtrn_err_q  <= 1'b0;
    end else begin
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
      ar_size_q   <= ar_size_d;
      ar_id_q     <= ar_id_d;
      rtrn_vld_q  <= rtrn_vld_d;
      rtrn_data_q <= rtrn_data_d;
      rtrn_tid_q  <= rtrn_tid_d;
      rtrn_err_q  <= rtrn_err_d;
    end
  end

  assign mem_data_ack_o = accept;
  assign mem_rtrn_vld_o = rtrn_vld_q;
  assign mem_rtrn_o     = '{rtype: ICACHE_IFILL_ACK, data: rtrn_data_q, inv: '0, tid: rtrn_tid_q};
  assign busy_o         = (|slot_valid) | ar_valid_q | rtrn_vld_q;

  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_addr  = ar_addr_q;
  assign axi.ar_len   = ar_len_q;
  assign axi.ar_size  = ar_size_q;
  assign axi.ar_burst = AxiBurstIncr;
  assign axi.ar_id    = ar_id_q;
  assign axi.r_ready  = 1'b1;
  assign axi.aw_valid = 1'b0;
  assign axi.w_valid  = 1'b0;
  assign axi.b_ready  = 1'b1;

  assign rid_alloc = |(slot_hit & slot_valid);

  a_rid_alloc: assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi.r_valid |-> rid_alloc);
  a_rlast_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (axi.r_valid && rid_alloc) |-> (axi.r_last == |(slot_hit & slot_last)));
  a_clr_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    clr_i |-> !busy_o);

endmodule

// File: tb/tb_icache_axi_refill_unit.sv
// Directed bench: 64-bit and 128-bit data-path instances of the refill unit.
module tb_icache_axi_refill_unit;
  import icache_axi_refill_unit_pkg::*;

  logic clk, rst_n;
  int checks, errors;

  logic         req64, ack64, vld64, busy64;
  icache_req_t  mreq64;
  icache_rtrn_t rtrn64;
  logic         req128, ack128, vld128, busy128;
  icache_req_t  mreq128;
  icache_rtrn_t rtrn128;
`ifdef CVA6_ICACHE_REFILL_ERR_EN
  logic err64, err128;
`endif

  icache_axi_refill_unit_if #(.AxiAddrWidth(64), .AxiDataWidth(64), .AxiIdWidth(4)) ax64 ();
  icache_axi_refill_unit_if #(.AxiAddrWidth(64), .AxiDataWidth(128), .AxiIdWidth(4)) ax128 ();

  icache_axi_refill_unit #(
    .LineWidth(128), .AxiAddrWidth(64), .AxiDataWidth(64), .AxiIdWidth(4), .NumOutstanding(2)
  ) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0),
    .mem_data_req_i(req64), .mem_data_ack_o(ack64), .mem_data_i(mreq64),
    .mem_rtrn_vld_o(vld64), .mem_rtrn_o(rtrn64), .busy_o(busy64),
`ifdef CVA6_ICACHE_REFILL_ERR_EN
    .err_o(err64),
`endif
    .axi(ax64)
  );

  icache_axi_refill_unit #(
    .LineWidth(128), .AxiAddrWidth(64), .AxiDataWidth(128), .AxiIdWidth(4), .NumOutstanding(2)
  ) u_dut128 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(1'b0),
    .mem_data_req_i(req128), .mem_data_ack_o(ack128), .mem_data_i(mreq128),
    .mem_rtrn_vld_o(vld128), .mem_rtrn_o(rtrn128), .busy_o(busy128),
`ifdef CVA6_ICACHE_REFILL_ERR_EN
    .err_o(err128),
`endif
    .axi(ax128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic rbeat64(input logic [3:0] id, input logic [63:0] d, input logic last,
                         input logic [1:0] resp);
    ax64.r_valid = 1'b1; ax64.r_id = id; ax64.r_data = d; ax64.r_last = last;
    ax64.r_resp = resp;
  endtask

  task automatic ridle64();
    ax64.r_valid = 1'b0; ax64.r_last = 1'b0; ax64.r_resp = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req64 = 1'b0; req128 = 1'b0; mreq64 = '0; mreq128 = '0;
    ax64.ar_ready = 1'b0; ax64.r_id = '0; ax64.r_data = '0; ridle64();
    ax128.ar_ready = 1'b0; ax128.r_valid = 1'b0; ax128.r_id = '0; ax128.r_data = '0;
    ax128.r_last = 1'b0; ax128.r_resp = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack64); end
    checks++; if (vld64 !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld64); end
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy64); end
    checks++; if (ax64.ar_valid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b exp 0", ax64.ar_valid); end
    checks++; if (rtrn64 !== '0) begin errors++; $display("FAIL reset_rtrn got %h exp 0", rtrn64); end
    checks++; if (busy128 !== 1'b0) begin errors++; $display("FAIL reset_busy128 got %b exp 0", busy128); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cached_miss();
    @(negedge clk); mreq64 = '{paddr: 64'h8000_0010, nc: 1'b0, tid: 2'd0}; req64 = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL miss_ack got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; #1;
    checks++; if (ax64.ar_valid !== 1'b1) begin errors++; $display("FAIL miss_arvalid got %b exp 1", ax64.ar_valid); end
    checks++; if (ax64.ar_addr !== 64'h8000_0010) begin errors++; $display("FAIL miss_araddr got %h exp 80000010", ax64.ar_addr); end
    checks++; if (ax64.ar_len !== 8'd1) begin errors++; $display("FAIL miss_arlen got %0d exp 1", ax64.ar_len); end
    checks++; if (ax64.ar_size !== 3'd3) begin errors++; $display("FAIL miss_arsize got %0d exp 3", ax64.ar_size); end
    checks++; if (ax64.ar_burst !== 2'b01) begin errors++; $display("FAIL miss_arburst got %0d exp 1", ax64.ar_burst); end
    checks++; if (ax64.ar_id !== 4'd0) begin errors++; $display("FAIL miss_arid got %0d exp 0", ax64.ar_id); end
    checks++; if (busy64 !== 1'b1) begin errors++; $display("FAIL miss_busy got %b exp 1", busy64); end
    ax64.ar_ready = 1'b1;
    @(negedge clk); ax64.ar_ready = 1'b0; rbeat64(4'd0, 64'hA, 1'b0, 2'b00); #1;
    checks++; if (ax64.ar_valid !== 1'b0) begin errors++; $display("FAIL miss_arvalid_drop got %b exp 0", ax64.ar_valid); end
    checks++; if (vld64 !== 1'b0) begin errors++; $display("FAIL miss_early_vld got %b exp 0", vld64); end
    @(negedge clk); rbeat64(4'd0, 64'hB, 1'b1, 2'b00); #1;
    checks++; if (vld64 !== 1'b0) begin errors++; $display("FAIL miss_vld_rlast_cycle got %b exp 0", vld64); end
    @(negedge clk); ridle64(); #1;
    checks++; if (vld64 !== 1'b1) begin errors++; $display("FAIL miss_vld got %b exp 1", vld64); end
    checks++; if (rtrn64.data !== {64'hB, 64'hA}) begin errors++; $display("FAIL miss_data got %h exp %h", rtrn64.data, {64'hB, 64'hA}); end
    checks++; if (rtrn64.tid !== 2'd0) begin errors++; $display("FAIL miss_tid got %0d exp 0", rtrn64.tid); end
    checks++; if (rtrn64.rtype !== ICACHE_IFILL_ACK) begin errors++; $display("FAIL miss_rtype got %0d exp 0", rtrn64.rtype); end
    @(negedge clk); #1;
    checks++; if (vld64 !== 1'b0) begin errors++; $display("FAIL miss_vld_pulse got %b exp 0", vld64); end
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL miss_idle got %b exp 0", busy64); end
  endtask

  task automatic test_bypass_128();
    @(negedge clk); mreq128 = '{paddr: 64'h1008, nc: 1'b1, tid: 2'd3}; req128 = 1'b1; #1;
    checks++; if (ack128 !== 1'b1) begin errors++; $display("FAIL nc_ack got %b exp 1", ack128); end
    @(negedge clk); req128 = 1'b0; #1;
    checks++; if (ax128.ar_addr !== 64'h1008) begin errors++; $display("FAIL nc_araddr got %h exp 1008", ax128.ar_addr); end
    checks++; if (ax128.ar_len !== 8'd0) begin errors++; $display("FAIL nc_arlen got %0d exp 0", ax128.ar_len); end
    checks++; if (ax128.ar_size !== 3'd3) begin errors++; $display("FAIL nc_arsize got %0d exp 3", ax128.ar_size); end
    ax128.ar_ready = 1'b1;
    @(negedge clk); ax128.ar_ready = 1'b0; ax128.r_valid = 1'b1; ax128.r_id = 4'd0;
    ax128.r_data = {64'h22, 64'h11}; ax128.r_last = 1'b1;
    @(negedge clk); ax128.r_valid = 1'b0; ax128.r_last = 1'b0; #1;
    checks++; if (vld128 !== 1'b1) begin errors++; $display("FAIL nc_vld got %b exp 1", vld128); end
    checks++; if (rtrn128.data !== 128'h22) begin errors++; $display("FAIL nc_data got %h exp 22", rtrn128.data); end
    checks++; if (rtrn128.tid !== 2'd3) begin errors++; $display("FAIL nc_tid got %0d exp 3", rtrn128.tid); end
    // Full-line request on the wide path: one beat of 16 bytes.
    @(negedge clk); mreq128 = '{paddr: 64'h2034, nc: 1'b0, tid: 2'd1}; req128 = 1'b1; #1;
    checks++; if (ack128 !== 1'b1) begin errors++; $display("FAIL w_ack got %b exp 1", ack128); end
    @(negedge clk); req128 = 1'b0; #1;
    checks++; if (ax128.ar_addr !== 64'h2030) begin errors++; $display("FAIL w_araddr got %h exp 2030", ax128.ar_addr); end
    checks++; if (ax128.ar_len !== 8'd0) begin errors++; $display("FAIL w_arlen got %0d exp 0", ax128.ar_len); end
    checks++; if (ax128.ar_size !== 3'd4) begin errors++; $display("FAIL w_arsize got %0d exp 4", ax128.ar_size); end
    ax128.ar_ready = 1'b1;
    @(negedge clk); ax128.ar_ready = 1'b0; ax128.r_valid = 1'b1; ax128.r_id = 4'd0;
    ax128.r_data = 128'hCAFE_0000_0000_0001_BEEF_0000_0000_0002; ax128.r_last = 1'b1;
    @(negedge clk); ax128.r_valid = 1'b0; ax128.r_last = 1'b0; #1;
    checks++; if (rtrn128.data !== 128'hCAFE_0000_0000_0001_BEEF_0000_0000_0002) begin errors++; $display("FAIL w_data got %h", rtrn128.data); end
    checks++; if (rtrn128.tid !== 2'd1) begin errors++; $display("FAIL w_tid got %0d exp 1", rtrn128.tid); end
  endtask

  task automatic test_out_of_order();
    @(negedge clk); mreq64 = '{paddr: 64'h100, nc: 1'b0, tid: 2'd1}; req64 = 1'b1;
    ax64.ar_ready = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL ooo_ack1 got %b exp 1", ack64); end
    @(negedge clk); mreq64 = '{paddr: 64'h200, nc: 1'b0, tid: 2'd2}; #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL ooo_ack_arbusy got %b exp 0", ack64); end
    checks++; if (ax64.ar_id !== 4'd0) begin errors++; $display("FAIL ooo_arid0 got %0d exp 0", ax64.ar_id); end
    @(negedge clk); #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL ooo_ack2 got %b exp 1", ack64); end
    @(negedge clk); mreq64 = '{paddr: 64'h300, nc: 1'b0, tid: 2'd3}; #1;
    checks++; if (ax64.ar_id !== 4'd1) begin errors++; $display("FAIL ooo_arid1 got %0d exp 1", ax64.ar_id); end
    checks++; if (ax64.ar_addr !== 64'h200) begin errors++; $display("FAIL ooo_araddr1 got %h exp 200", ax64.ar_addr); end
    @(negedge clk); rbeat64(4'd1, 64'h11, 1'b0, 2'b00); #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL ooo_ack_full got %b exp 0", ack64); end
    @(negedge clk); rbeat64(4'd1, 64'h12, 1'b1, 2'b00); #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL ooo_ack_full_rlast got %b exp 0", ack64); end
    @(negedge clk); rbeat64(4'd0, 64'h01, 1'b0, 2'b00); #1;
    checks++; if (vld64 !== 1'b1) begin errors++; $display("FAIL ooo_vld_a got %b exp 1", vld64); end
    checks++; if (rtrn64.tid !== 2'd2) begin errors++; $display("FAIL ooo_tid_a got %0d exp 2", rtrn64.tid); end
    checks++; if (rtrn64.data !== {64'h12, 64'h11}) begin errors++; $display("FAIL ooo_data_a got %h", rtrn64.data); end
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL ooo_ack3 got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; rbeat64(4'd0, 64'h02, 1'b1, 2'b00); #1;
    checks++; if (ax64.ar_id !== 4'd1) begin errors++; $display("FAIL ooo_arid3 got %0d exp 1", ax64.ar_id); end
    checks++; if (ax64.ar_addr !== 64'h300) begin errors++; $display("FAIL ooo_araddr3 got %h exp 300", ax64.ar_addr); end
    @(negedge clk); rbeat64(4'd1, 64'h31, 1'b0, 2'b00); #1;
    checks++; if (rtrn64.tid !== 2'd1) begin errors++; $display("FAIL ooo_tid_b got %0d exp 1", rtrn64.tid); end
    checks++; if (rtrn64.data !== {64'h02, 64'h01}) begin errors++; $display("FAIL ooo_data_b got %h", rtrn64.data); end
    @(negedge clk); rbeat64(4'd1, 64'h32, 1'b1, 2'b00);
    @(negedge clk); ridle64(); ax64.ar_ready = 1'b0; #1;
    checks++; if (rtrn64.tid !== 2'd3) begin errors++; $display("FAIL ooo_tid_c got %0d exp 3", rtrn64.tid); end
    checks++; if (rtrn64.data !== {64'h32, 64'h31}) begin errors++; $display("FAIL ooo_data_c got %h", rtrn64.data); end
    @(negedge clk); #1;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL ooo_idle got %b exp 0", busy64); end
  endtask

  task automatic test_ar_backpressure();
    @(negedge clk); mreq64 = '{paddr: 64'h4048, nc: 1'b0, tid: 2'd1}; req64 = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL bp_ack1 got %b exp 1", ack64); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) mreq64 = '{paddr: 64'h5000, nc: 1'b0, tid: 2'd2};
      #1;
      checks++; if (ax64.ar_valid !== 1'b1) begin errors++; $display("FAIL bp_arvalid[%0d] got %b exp 1", k, ax64.ar_valid); end
      checks++; if ({ax64.ar_addr, ax64.ar_len, ax64.ar_size, ax64.ar_id} !== {64'h4040, 8'd1, 3'd3, 4'd0}) begin
        errors++; $display("FAIL bp_fields[%0d] got %h/%0d/%0d/%0d exp 4040/1/3/0", k, ax64.ar_addr, ax64.ar_len, ax64.ar_size, ax64.ar_id);
      end
      checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL bp_ack2_held[%0d] got %b exp 0", k, ack64); end
    end
    @(negedge clk); ax64.ar_ready = 1'b1; #1;
    checks++; if (ack64 !== 1'b0) begin errors++; $display("FAIL bp_ack2_handshake got %b exp 0", ack64); end
    @(negedge clk); #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL bp_ack2 got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; #1;
    checks++; if ({ax64.ar_valid, ax64.ar_id, ax64.ar_addr} !== {1'b1, 4'd1, 64'h5000}) begin
      errors++; $display("FAIL bp_ar2 got %b/%0d/%h exp 1/1/5000", ax64.ar_valid, ax64.ar_id, ax64.ar_addr);
    end
    @(negedge clk); ax64.ar_ready = 1'b0; rbeat64(4'd0, 64'h41, 1'b0, 2'b00);
    @(negedge clk); rbeat64(4'd0, 64'h42, 1'b1, 2'b00);
    @(negedge clk); rbeat64(4'd1, 64'h51, 1'b0, 2'b00); #1;
    checks++; if ({vld64, rtrn64.tid, rtrn64.data} !== {1'b1, 2'd1, 64'h42, 64'h41}) begin
      errors++; $display("FAIL bp_rtrn1 got %b/%0d/%h", vld64, rtrn64.tid, rtrn64.data);
    end
    @(negedge clk); rbeat64(4'd1, 64'h52, 1'b1, 2'b00);
    @(negedge clk); ridle64(); #1;
    checks++; if ({vld64, rtrn64.tid, rtrn64.data} !== {1'b1, 2'd2, 64'h52, 64'h51}) begin
      errors++; $display("FAIL bp_rtrn2 got %b/%0d/%h", vld64, rtrn64.tid, rtrn64.data);
    end
  endtask

  task automatic test_error_path();
    @(negedge clk); mreq64 = '{paddr: 64'h600, nc: 1'b0, tid: 2'd2}; req64 = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL err_ack got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; ax64.ar_ready = 1'b1;
    @(negedge clk); ax64.ar_ready = 1'b0; rbeat64(4'd0, 64'hAA, 1'b0, 2'b10);
    @(negedge clk); rbeat64(4'd0, 64'hBB, 1'b1, 2'b00);
    @(negedge clk); ridle64(); #1;
    checks++; if (vld64 !== 1'b1) begin errors++; $display("FAIL err_vld got %b exp 1", vld64); end
    checks++; if (rtrn64.tid !== 2'd2) begin errors++; $display("FAIL err_tid got %0d exp 2", rtrn64.tid); end
`ifdef CVA6_ICACHE_REFILL_ERR_EN
    checks++; if (err64 !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", err64); end
    checks++; if (rtrn64.data !== 128'h0) begin errors++; $display("FAIL err_data got %h exp 0", rtrn64.data); end
    @(negedge clk); #1;
    checks++; if (err64 !== 1'b0) begin errors++; $display("FAIL err_flag_pulse got %b exp 0", err64); end
`else
    checks++; if (rtrn64.data !== {64'hBB, 64'hAA}) begin errors++; $display("FAIL err_data_pass got %h", rtrn64.data); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); mreq64 = '{paddr: 64'h700, nc: 1'b0, tid: 2'd1}; req64 = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL rmb_ack got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; ax64.ar_ready = 1'b1;
    @(negedge clk); ax64.ar_ready = 1'b0; rbeat64(4'd0, 64'h71, 1'b0, 2'b00); #1;
    checks++; if (busy64 !== 1'b1) begin errors++; $display("FAIL rmb_busy_pre got %b exp 1", busy64); end
    @(negedge clk); ridle64(); rst_n = 1'b0; #1;
    checks++; if ({vld64, busy64, ack64, ax64.ar_valid} !== 4'b0000) begin
      errors++; $display("FAIL rmb_outputs got %b exp 0000", {vld64, busy64, ack64, ax64.ar_valid});
    end
    checks++; if (rtrn64 !== '0) begin errors++; $display("FAIL rmb_rtrn got %h exp 0", rtrn64); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mreq64 = '{paddr: 64'h780, nc: 1'b0, tid: 2'd3}; req64 = 1'b1; #1;
    checks++; if (ack64 !== 1'b1) begin errors++; $display("FAIL rmb_ack2 got %b exp 1", ack64); end
    @(negedge clk); req64 = 1'b0; ax64.ar_ready = 1'b1; #1;
    checks++; if ({ax64.ar_valid, ax64.ar_id, ax64.ar_addr} !== {1'b1, 4'd0, 64'h780}) begin
      errors++; $display("FAIL rmb_ar got %b/%0d/%h exp 1/0/780", ax64.ar_valid, ax64.ar_id, ax64.ar_addr);
    end
    @(negedge clk); ax64.ar_ready = 1'b0; rbeat64(4'd0, 64'h81, 1'b0, 2'b00);
    @(negedge clk); rbeat64(4'd0, 64'h82, 1'b1, 2'b00);
    @(negedge clk); ridle64(); #1;
    checks++; if ({vld64, rtrn64.tid, rtrn64.data} !== {1'b1, 2'd3, 64'h82, 64'h81}) begin
      errors++; $display("FAIL rmb_rtrn2 got %b/%0d/%h", vld64, rtrn64.tid, rtrn64.data);
    end
    @(negedge clk); #1;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL rmb_idle got %b exp 0", busy64); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cached_miss();
    test_bypass_128();
    test_out_of_order();
    test_ar_backpressure();
    test_error_path();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
